csel_adder_pipe: RTL
====================

Name: csel_adder_pipe

Overview:
- Parametrised signed carry-select adder/subtractor. Generalises the team's 8-bit signed ripple-carry adder to WIDTH bits.
- Adds an add/subtract mode, a 2-stage pipeline and a valid/ready handshake.
- Used in the lab datapath wherever a registered signed add/sub with carry and overflow flags is needed at full throughput.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥2 and divisible by BLK.
- BLK, 4, carry-select segment width in bits; NSEG = WIDTH/BLK segments.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand beat.
- a  in  WIDTH  signed operand A.
- b  in  WIDTH  signed operand B.
- cin  in  1  carry in; used in add mode only.
- sub  in  1  0 = A+B+cin, 1 = A−B.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  signed result.
- cout  out  1  carry out of the MSB; in subtract mode this is not-borrow.
- v  out  1  signed overflow.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: out_valid=0, sum=0, cout=0, v=0, all internal valids=0. in_ready=1 during and after reset.
- Effective operands:
  - bb = sub ? ~b : b
  - c0 = sub ? 1 : cin
- Stage S1:
  - Registered on accept (in_valid && in_ready).
  - For each segment k, computes two ripple sums from a and bb: one with carry-in 0, one with carry-in 1.
  - Each result holds segment sum, segment carry-out, and carry into the segment MSB.
  - Segment 0 is computed only with c0.
  - All results register together with s1_valid.
- Stage S2 (output registers):
  - Select chain: segment k picks its carry-0 or carry-1 result using the selected carry-out of segment k−1.
  - cout = c[WIDTH−1].
  - v = c[WIDTH−1] ^ c[WIDTH−2].
- Latency: exactly 2 clk from accept to out_valid with no stall. Throughput 1 beat/cycle.
- Handshake:
  - stall = out_valid && !out_ready.
  - S2 loads when !stall.
  - S1 loads when !s1_valid || !stall.
  - in_ready = !s1_valid || !stall (combinational).
  - While stalled, sum/cout/v/out_valid hold stable.
  - out_valid drops only after a transfer that has no new S1 data behind it.
- Simultaneous transfer: out_valid && out_ready together with an S1 beat moves that beat into S2 in the same cycle, with no bubble.
- Empty-pipe accept: out_valid rises 2 cycles later.
- Mid-operation reset: all in-flight beats are discarded immediately (asynchronous). No output beat appears after reset release until a new accept.
- Output flags (cout, v) are computed from the exact result, before any saturation.
- WIDTH==BLK: single segment, no select chain; behaves as a pipelined ripple-carry adder.

Optional Feature:
- Macro: CSEL_SATURATE_EN.
- When defined and v=1, sum clamps:
  - positive overflow (a sign = bb sign = 0) → 2^(WIDTH−1)−1
  - negative overflow → −2^(WIDTH−1)
- cout and v are unchanged by clamping.
- When undefined, sum is the wrapped two's-complement result.
- Latency is identical either way.

Decomposition:
- Package adder_pkg:
  - constant function for NSEG
  - typedef seg_res_t {sum[BLK], co, cmsb}
  - elaboration-time legality check for WIDTH % BLK
- Sub-module rca_seg (parametrised BLK): combinational ripple-carry segment returning sum, carry-out and MSB carry-in.
  - Instantiated 2×NSEG−1 times.

Test Plan (WIDTH=16, BLK=4 unless noted):
- add, a=0x7FFF, b=0x0001, cin=0 → 2 cycles later sum=0x8000, v=1, cout=0. With CSEL_SATURATE_EN: sum=0x7FFF, v=1.
- sub, a=0x8000, b=0x0001 → sum=0x7FFF, v=1, cout=1. Saturated build: sum=0x8000.
- add, a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, v=0 (carry ripples across all 4 segments).
- Stream 5 beats with in_valid=1 and out_ready=0 from cycle 2 for 3 cycles:
  - in_ready falls after 2 accepted beats.
  - First result is held unchanged.
  - On out_ready=1, beats drain in order with no loss or duplication, 1/cycle.
- Assert rst_n=0 with 2 beats in flight → out_valid=0, sum=0 immediately; no output after release until a new accept.
- WIDTH=8, BLK=8, random 1000 add/sub beats with random out_ready → every result matches the reference model of {cout,sum} and v.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the carry-select add/sub pipeline.
// Segment results carry a fixed-width sum field; users read only the low BLK bits.
package adder_pkg;

    localparam int SEG_W_MAX = 32;

    typedef struct packed {
        logic [SEG_W_MAX-1:0] sum;
        logic                 co;
        logic                 cmsb;
    } seg_res_t;

    function automatic int seg_count(input int width, input int blk);
        return width / blk;
    endfunction

    function automatic bit seg_cfg_ok(input int width, input int blk);
        return (width >= 2) && (blk >= 1) && (blk < SEG_W_MAX) && ((width % blk) == 0);
    endfunction

endpackage

// File: rtl/rca_seg.sv
// One BLK-bit ripple-carry segment: sum, carry-out and the carry into the segment MSB.
// Purely combinational; no handshake.
module rca_seg
    import adder_pkg::*;
#(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           ci,
    output seg_res_t       res
);

    logic [BLK:0]   c;
    logic [BLK-1:0] s;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < BLK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        res              = '0;
        res.sum[BLK-1:0] = s;
        res.co           = c[BLK];
        res.cmsb         = c[BLK-1];
    end

endmodule

// File: rtl/csel_adder_pipe.sv
// Signed carry-select add/sub with cout/overflow flags; CSEL_SATURATE_EN clamps sum on overflow.
// Latency: 2 cycles from accept to out_valid, 1 beat/cycle sustained.
// Backpressure: outputs hold while out_valid && !out_ready; in_ready = !s1_valid || !stall.
module csel_adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             v
);

    localparam int NSEG = seg_count(WIDTH, BLK);

    if (!seg_cfg_ok(WIDTH, BLK)) begin : g_cfg_err
        $error("csel_adder_pipe: WIDTH must be >= 2 and a multiple of BLK");
    end

    logic [WIDTH-1:0] bb;
    logic             c0;
    logic             stall;
    logic             s1_load;

    seg_res_t seg_lo [NSEG];
    seg_res_t seg_hi [NSEG];

    logic     s1_valid_q, s1_valid_d;
    seg_res_t s1_lo_q [NSEG];
    seg_res_t s1_lo_d [NSEG];
    seg_res_t s1_hi_q [NSEG];
    seg_res_t s1_hi_d [NSEG];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             v_q, v_d;

    logic [WIDTH-1:0] sum_exact;
    logic [WIDTH-1:0] sum_final;
    logic             carry_sel;
    logic             cmsb_sel;
    logic             v_exact;
    seg_res_t         sel;
    logic             unused_fold;

    assign bb       = sub ? ~b : b;
    assign c0       = sub ? 1'b1 : cin;
    assign stall    = out_valid_q && !out_ready;
    assign s1_load  = !s1_valid_q || !stall;
    assign in_ready = s1_load;

    // Segment 0 sees the real carry-in; higher segments precompute both carry cases.
    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        if (k == 0) begin : g_first
            rca_seg #(.BLK(BLK)) u_seg (
                .a   (a[BLK-1:0]),
                .b   (bb[BLK-1:0]),
                .ci  (c0),
                .res (seg_lo[k])
            );
            assign seg_hi[k] = '0;
        end else begin : g_pair
            rca_seg #(.BLK(BLK)) u_seg_c0 (
                .a   (a[k*BLK +: BLK]),
                .b   (bb[k*BLK +: BLK]),
                .ci  (1'b0),
                .res (seg_lo[k])
            );
            rca_seg #(.BLK(BLK)) u_seg_c1 (
                .a   (a[k*BLK +: BLK]),
                .b   (bb[k*BLK +: BLK]),
                .ci  (1'b1),
                .res (seg_hi[k])
            );
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_lo_d    = s1_lo_q;
        s1_hi_d    = s1_hi_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_lo_d = seg_lo;
                s1_hi_d = seg_hi;
            end
        end
    end

    // Select chain: carry_sel starts at 0 so segment 0 always takes its only result.
    always_comb begin
        sel         = '0;
        carry_sel   = 1'b0;
        cmsb_sel    = 1'b0;
        sum_exact   = '0;
        unused_fold = ^s1_hi_q[0];
        for (int k = 0; k < NSEG; k++) begin
            sel                      = carry_sel ? s1_hi_q[k] : s1_lo_q[k];
            sum_exact[k*BLK +: BLK]  = sel.sum[BLK-1:0];
            cmsb_sel                 = sel.cmsb;
            carry_sel                = sel.co;
            unused_fold              = unused_fold ^ (^sel.sum);
        end
    end

    assign v_exact = carry_sel ^ cmsb_sel;

`ifdef CSEL_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // On overflow the wrapped sign is the inverse of the true sign.
    always_comb begin
        sum_final = sum_exact;
        if (v_exact) begin
            sum_final = sum_exact[WIDTH-1] ? SAT_MAX : SAT_MIN;
        end
    end
`else
    assign sum_final = sum_exact;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        v_d         = v_q;
        if (!stall) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d  = sum_final;
                cout_d = carry_sel;
                v_d    = v_exact;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            for (int k = 0; k < NSEG; k++) begin
                s1_lo_q[k] <= '0;
                s1_hi_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_lo_q     <= s1_lo_d;
            s1_hi_q     <= s1_hi_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            v_q         <= v_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign v         = v_q;

endmodule
